lc4_perf_monitor: RTL and testbench

Synthesizable, parametrised performance and halt monitor that sits beside lc4_processor and observes its test_stall/test_cur_insn outputs. It keeps a bank of per-category cycle counters: total cycles, executed instructions, and one bin per stall code. It detects the halt instruction and stops counting. Counters are read back through a one-cycle-latency read port, so on-chip runs report CPI data without the simulation bench.

---
 rtl/lc4_perf_monitor_if.sv | 32 +++
 rtl/lc4_perf_monitor.sv | 108 ++++++++++
 tb/tb_lc4_perf_monitor.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/lc4_perf_monitor_if.sv
// Observation, control and read-back bundle between a host and lc4_perf_monitor.
interface lc4_perf_monitor_if #(
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned STALL_BITS = 2,
  parameter int unsigned INSN_BITS  = 20,
  parameter int unsigned SEL_BITS   = 3
);
  logic                  gwe;
  logic                  i_start;
  logic                  i_clear;
  logic [STALL_BITS-1:0] i_stall;
  logic [INSN_BITS-1:0]  i_insn;
  logic                  i_rd_req;
  logic [SEL_BITS-1:0]   i_rd_sel;
  logic                  o_rd_valid;
  logic [CNT_WIDTH-1:0]  o_rd_data;
  logic                  o_running;
  logic                  o_halted;
  logic                  o_overflow;

  // Host side: drives control/observation, receives read data and status.
  modport master (
    output gwe, i_start, i_clear, i_stall, i_insn, i_rd_req, i_rd_sel,
    input  o_rd_valid, o_rd_data, o_running, o_halted, o_overflow
  );

  // Monitor side.
  modport slave (
    input  gwe, i_start, i_clear, i_stall, i_insn, i_rd_req, i_rd_sel,
    output o_rd_valid, o_rd_data, o_running, o_halted, o_overflow
  );
endinterface

// File: rtl/lc4_perf_monitor.sv
// Cycle/stall-category performance counters with halt detection and a
// one-cycle-latency read port.
module lc4_perf_monitor #(
  parameter int unsigned          CNT_WIDTH  = 32,
  parameter int unsigned          STALL_BITS = 2,
  parameter int unsigned          INSN_BITS  = 20,
  parameter logic [INSN_BITS-1:0] HALT_INSN  = INSN_BITS'(20'h88000),
  parameter bit                   SATURATE   = 1'b1,
  parameter int unsigned          SEL_BITS   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  lc4_perf_monitor_if.slave    bus
);

  localparam int unsigned NUM_BINS = 2 ** STALL_BITS;
  localparam int unsigned NUM_CNT  = 1 + NUM_BINS;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t               state_q, state_d;
  logic                 running_q, halted_q;
  logic                 count_en_c;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CNT];
  logic                 ovf_q;
  logic [CNT_WIDTH-1:0] rd_mux_c;
  logic                 rd_valid_q;
  logic [CNT_WIDTH-1:0] rd_data_q;

  // State register; status flags are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == RUN);
      halted_q  <= (state_d == HALTED);
    end
  end

  // Next state and count enable; clear suppresses counting in RUN.
  always_comb begin
    state_d    = state_q;
    count_en_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_start) state_d = RUN;
      end
      RUN: begin
        if (!bus.i_clear && bus.gwe) begin
          count_en_c = 1'b1;
          if (bus.i_stall == '0 && bus.i_insn == HALT_INSN) state_d = HALTED;
        end
      end
      HALTED: begin
        if (bus.i_clear) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter bank: counter 0 counts every qualified cycle, 1+stall counts its bin.
  always_ff @(posedge clk) begin
    if (rst || bus.i_clear) begin
      for (int unsigned i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
      ovf_q <= 1'b0;
    end else if (count_en_c) begin
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        if ((i == 0) || (STALL_BITS'(i - 1) == bus.i_stall)) begin
          if (cnt_q[i] == '1) begin
            ovf_q <= 1'b1;
            if (!SATURATE) cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  // Read select mux; out-of-range indices read as zero.
  always_comb begin
    rd_mux_c = '0;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      if (bus.i_rd_sel == SEL_BITS'(i)) rd_mux_c = cnt_q[i];
    end
  end

  // Read port: snapshot of pre-update counter value, data held when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= bus.i_rd_req;
      if (bus.i_rd_req) rd_data_q <= rd_mux_c;
    end
  end

  assign bus.o_rd_valid = rd_valid_q;
  assign bus.o_rd_data  = rd_data_q;
  assign bus.o_running  = running_q;
  assign bus.o_halted   = halted_q;
  assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_lc4_perf_monitor.sv
// Self-checking bench for lc4_perf_monitor: one 32-bit saturating instance
// and two 4-bit instances (saturating / wrapping) driven in lockstep.
module tb_lc4_perf_monitor;

  localparam logic [19:0] HALT = 20'h88000;
  localparam int S_IDLE = 0, S_RUN = 1, S_HALT = 2;

  logic        clk = 1'b0;
  logic        rst, gwe, start, clear, rd_req;
  logic [1:0]  stall;
  logic [19:0] insn;
  logic [2:0]  rd_sel;

  int total = 0;
  int bad   = 0;

  // Reference model: index 0 = 32-bit sat, 1 = 4-bit sat, 2 = 4-bit wrap.
  longint unsigned m_cnt [3][5];
  bit              m_ovf [3];
  int              m_st  [3];
  bit              m_rv  [3];
  longint unsigned m_rd  [3];

  lc4_perf_monitor_if #(.CNT_WIDTH(32)) if_m ();
  lc4_perf_monitor_if #(.CNT_WIDTH(4))  if_s ();
  lc4_perf_monitor_if #(.CNT_WIDTH(4))  if_w ();

  assign if_m.gwe = gwe;     assign if_s.gwe = gwe;     assign if_w.gwe = gwe;
  assign if_m.i_start = start; assign if_s.i_start = start; assign if_w.i_start = start;
  assign if_m.i_clear = clear; assign if_s.i_clear = clear; assign if_w.i_clear = clear;
  assign if_m.i_stall = stall; assign if_s.i_stall = stall; assign if_w.i_stall = stall;
  assign if_m.i_insn = insn;   assign if_s.i_insn = insn;   assign if_w.i_insn = insn;
  assign if_m.i_rd_req = rd_req; assign if_s.i_rd_req = rd_req; assign if_w.i_rd_req = rd_req;
  assign if_m.i_rd_sel = rd_sel; assign if_s.i_rd_sel = rd_sel; assign if_w.i_rd_sel = rd_sel;

  lc4_perf_monitor #(.CNT_WIDTH(32), .SATURATE(1'b1)) u_m (.clk(clk), .rst(rst), .bus(if_m));
  lc4_perf_monitor #(.CNT_WIDTH(4),  .SATURATE(1'b1)) u_s (.clk(clk), .rst(rst), .bus(if_s));
  lc4_perf_monitor #(.CNT_WIDTH(4),  .SATURATE(1'b0)) u_w (.clk(clk), .rst(rst), .bus(if_w));

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one edge of the behavioural rules to model instance d.
  function automatic void model_step(int d);
    longint unsigned lim = (d == 0) ? 64'hFFFF_FFFF : 64'hF;
    bit sat = (d != 2);
    if (rst) begin
      for (int k = 0; k < 5; k++) m_cnt[d][k] = 0;
      m_ovf[d] = 0; m_st[d] = S_IDLE; m_rv[d] = 0; m_rd[d] = 0;
      return;
    end
    m_rv[d] = rd_req;
    if (rd_req) m_rd[d] = (rd_sel <= 3'd4) ? m_cnt[d][rd_sel] : 0;
    if (clear) begin
      for (int k = 0; k < 5; k++) m_cnt[d][k] = 0;
      m_ovf[d] = 0;
      if (m_st[d] == S_IDLE && start) m_st[d] = S_RUN;
      else if (m_st[d] == S_HALT) m_st[d] = S_IDLE;
    end else if (m_st[d] == S_IDLE) begin
      if (start) m_st[d] = S_RUN;
    end else if (m_st[d] == S_RUN && gwe) begin
      for (int k = 0; k < 5; k++) begin
        if (k == 0 || k == 1 + int'(stall)) begin
          if (m_cnt[d][k] == lim) begin
            m_ovf[d] = 1;
            if (!sat) m_cnt[d][k] = 0;
          end else m_cnt[d][k]++;
        end
      end
      if (stall == 2'd0 && insn == HALT) m_st[d] = S_HALT;
    end
  endfunction

  task automatic check_all();
    check("m.rd_valid", 64'(if_m.o_rd_valid), 64'(m_rv[0]));
    check("m.rd_data",  64'(if_m.o_rd_data),  m_rd[0]);
    check("m.running",  64'(if_m.o_running),  64'(m_st[0] == S_RUN));
    check("m.halted",   64'(if_m.o_halted),   64'(m_st[0] == S_HALT));
    check("m.overflow", 64'(if_m.o_overflow), 64'(m_ovf[0]));
    check("s.rd_valid", 64'(if_s.o_rd_valid), 64'(m_rv[1]));
    check("s.rd_data",  64'(if_s.o_rd_data),  m_rd[1]);
    check("s.running",  64'(if_s.o_running),  64'(m_st[1] == S_RUN));
    check("s.halted",   64'(if_s.o_halted),   64'(m_st[1] == S_HALT));
    check("s.overflow", 64'(if_s.o_overflow), 64'(m_ovf[1]));
    check("w.rd_valid", 64'(if_w.o_rd_valid), 64'(m_rv[2]));
    check("w.rd_data",  64'(if_w.o_rd_data),  m_rd[2]);
    check("w.running",  64'(if_w.o_running),  64'(m_st[2] == S_RUN));
    check("w.halted",   64'(if_w.o_halted),   64'(m_st[2] == S_HALT));
    check("w.overflow", 64'(if_w.o_overflow), 64'(m_ovf[2]));
  endtask

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_step(d);
    #1;
    check_all();
  endtask

  task automatic cyc(input logic g, input logic [1:0] s, input logic [19:0] ins);
    gwe = g; stall = s; insn = ins;
    tick();
    gwe = 1'b0;
  endtask

  // Unqualified read of one counter; result visible after return.
  task automatic rd(input logic [2:0] sel);
    gwe = 1'b0; rd_req = 1'b1; rd_sel = sel;
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    logic [1:0] codes [10];
    codes = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd3, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0};
    rst = 1'b1; gwe = 1'b0; start = 1'b0; clear = 1'b0; stall = '0;
    insn = '0; rd_req = 1'b0; rd_sel = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset.running", 64'(if_m.o_running), 64'd0);
    check("reset.rd_data", 64'(if_m.o_rd_data), 64'd0);

    // 1: stall-bin accounting
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) cyc(1'b1, codes[i], 20'h0);
    rd(3'd0); check("t1.idx0", 64'(if_m.o_rd_data), 64'd10);
    rd(3'd1); check("t1.idx1", 64'(if_m.o_rd_data), 64'd6);
    rd(3'd2); check("t1.idx2", 64'(if_m.o_rd_data), 64'd1);
    rd(3'd3); check("t1.idx3", 64'(if_m.o_rd_data), 64'd1);
    rd(3'd4); check("t1.idx4", 64'(if_m.o_rd_data), 64'd2);
    check("t1.running", 64'(if_m.o_running), 64'd1);

    // 2 (+6b): clear in RUN wins over increment, then halt on 5th qualified cycle
    clear = 1'b1; cyc(1'b1, 2'd0, 20'h0); clear = 1'b0;
    rd(3'd0); check("t6.clear_idx0", 64'(if_m.o_rd_data), 64'd0);
    check("t6.clear_running", 64'(if_m.o_running), 64'd1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'd0, 20'h0);
    cyc(1'b1, 2'd0, HALT);
    check("t2.halted", 64'(if_m.o_halted), 64'd1);
    rd(3'd0); check("t2.idx0", 64'(if_m.o_rd_data), 64'd5);
    start = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'd0, 20'h0);
    start = 1'b0;
    rd(3'd0); check("t2.frozen_idx0", 64'(if_m.o_rd_data), 64'd5);
    check("t2.still_halted", 64'(if_m.o_halted), 64'd1);

    // 3: gwe qualification; halt insn while gwe=0 is ignored
    clear = 1'b1; tick(); clear = 1'b0;
    check("t3.idle", 64'(if_m.o_halted), 64'd0);
    start = 1'b1; tick(); start = 1'b0;
    cyc(1'b1, 2'd0, 20'h0); cyc(1'b0, 2'd0, HALT);
    cyc(1'b1, 2'd0, 20'h0); cyc(1'b0, 2'd0, HALT);
    rd(3'd0); check("t3.idx0", 64'(if_m.o_rd_data), 64'd2);
    rd(3'd1); check("t3.idx1", 64'(if_m.o_rd_data), 64'd2);
    check("t3.running", 64'(if_m.o_running), 64'd1);

    // 4: 4-bit saturation and wrap
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 17; i++) cyc(1'b1, 2'd0, 20'h0);
    rd(3'd0); check("t4.wrap_idx0", 64'(if_w.o_rd_data), 64'd1);
    check("t4.wrap_ovf", 64'(if_w.o_overflow), 64'd1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'd0, 20'h0);
    rd(3'd0); check("t4.sat_idx0", 64'(if_s.o_rd_data), 64'd15);
    check("t4.sat_ovf", 64'(if_s.o_overflow), 64'd1);
    clear = 1'b1; tick(); clear = 1'b0;
    rd(3'd0); check("t4.clr_idx0", 64'(if_s.o_rd_data), 64'd0);
    check("t4.clr_ovf", 64'(if_s.o_overflow), 64'd0);

    // 5: pre-update read snapshot and out-of-range select
    for (int i = 0; i < 7; i++) cyc(1'b1, 2'd0, 20'h0);
    rd_req = 1'b1; rd_sel = 3'd0; cyc(1'b1, 2'd0, 20'h0); rd_req = 1'b0;
    check("t5.snap", 64'(if_m.o_rd_data), 64'd7);
    rd(3'd0); check("t5.after", 64'(if_m.o_rd_data), 64'd8);
    rd(3'd7); check("t5.oor_data", 64'(if_m.o_rd_data), 64'd0);
    check("t5.oor_valid", 64'(if_m.o_rd_valid), 64'd1);

    // 6a: reset mid-run
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 9; i++) cyc(1'b1, 2'd0, 20'h0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6.rst_running", 64'(if_m.o_running), 64'd0);
    check("t6.rst_valid", 64'(if_m.o_rd_valid), 64'd0);
    for (int k = 0; k < 5; k++) begin
      rd(3'(k)); check("t6.rst_idx", 64'(if_m.o_rd_data), 64'd0);
    end

    // Random traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 99) == 0);
      clear  = ($urandom_range(0, 29) == 0);
      start  = ($urandom_range(0, 7) == 0);
      gwe    = 1'($urandom);
      stall  = 2'($urandom);
      insn   = ($urandom_range(0, 7) == 0) ? HALT : 20'($urandom);
      rd_req = 1'($urandom);
      rd_sel = 3'($urandom);
      tick();
    end
    rst = 1'b0; clear = 1'b0; start = 1'b0; gwe = 1'b0; rd_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
